// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle carrying one pipeline entry (control + data).
// A stage takes the upstream side as slave and drives the downstream side as master.
interface pipe_stage_skid_if #(
  parameter int CTRL_W = 9,
  parameter int DATA_W = 111
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input  ready);
  modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a two-entry skid buffer, flush-to-bubble and a
// saturating counter of bubble cycles consumed downstream.
module pipe_stage_skid #(
  parameter int CTRL_W = 9,
  parameter int DATA_W = 111,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_stage_skid_if.slave     up,
  pipe_stage_skid_if.master    dn,
  output logic [CNT_W-1:0]     bubble_cnt
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic accept;
  logic drain;
  logic main_free;

  // Ready comes straight from the skid flop, so out_ready never reaches in_ready.
  assign up.ready  = ~skid_valid;
  assign accept    = up.valid & ~skid_valid;
  assign drain     = main_valid & dn.ready;
  assign main_free = ~main_valid | drain;

  assign dn.valid = main_valid;
  assign dn.ctrl  = main_ctrl & {CTRL_W{main_valid}};
  assign dn.data  = main_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (dn.ready && !main_valid && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + 1'b1;

      // Flush only drops the valid bits; payload registers keep their contents.
      if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (main_free) begin
        if (skid_valid) begin
          main_valid <= 1'b1;
          main_ctrl  <= skid_ctrl;
          main_data  <= skid_data;
          skid_valid <= 1'b0;
        end else if (accept) begin
          main_valid <= 1'b1;
          main_ctrl  <= up.ctrl;
          main_data  <= up.data;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_ctrl  <= up.ctrl;
        skid_data  <= up.data;
      end
    end
  end

endmodule
